// File: rtl/output_p4_arbiter_pkg.sv
// Shared definitions for the P4 output arbiter and related schedulers.
package output_p4_pkg;

    localparam int unsigned NUM_SLAVES  = 4;
    localparam int unsigned GRANT_WIDTH = 2;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_FORWARD = 1'b1
    } state_e;

    typedef logic [GRANT_WIDTH-1:0] grant_t;

endpackage

// File: rtl/output_p4_arbiter_rr_priority_select.sv
// Combinational round-robin pick: first valid requester after last_grant_i.
module rr_priority_select
    import output_p4_pkg::*;
(
    input  logic [NUM_SLAVES-1:0] valid_i,
    input  grant_t                last_grant_i,
    output grant_t                winner_o,
    output logic                  any_valid_o
);

    grant_t idx;

    // Scan farthest-first so the nearest valid requester overwrites the result.
    always_comb begin
        winner_o = '0;
        idx      = '0;
        for (int unsigned k = NUM_SLAVES; k >= 1; k--) begin
            idx = last_grant_i + grant_t'(k);
            if (valid_i[idx]) begin
                winner_o = idx;
            end
        end
    end

    assign any_valid_o = |valid_i;

endmodule

// File: rtl/output_p4_arbiter.sv
// Packet-granular round-robin merge of four P4 output streams into one
// AXI4-Stream, with per-source forwarded-packet counters.
module output_p4_arbiter
    import output_p4_pkg::*;
#(
    parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned CNT_WIDTH            = 32
) (
    input  logic                               axis_aclk,
    input  logic                               axis_reset,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s_axis_0_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_0_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_0_tuser,
    input  logic                               s_axis_0_tvalid,
    input  logic                               s_axis_0_tlast,
    output logic                               s_axis_0_tready,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s_axis_1_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_1_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_1_tuser,
    input  logic                               s_axis_1_tvalid,
    input  logic                               s_axis_1_tlast,
    output logic                               s_axis_1_tready,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s_axis_2_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_2_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_2_tuser,
    input  logic                               s_axis_2_tvalid,
    input  logic                               s_axis_2_tlast,
    output logic                               s_axis_2_tready,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s_axis_3_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_3_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_3_tuser,
    input  logic                               s_axis_3_tvalid,
    input  logic                               s_axis_3_tlast,
    output logic                               s_axis_3_tready,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
    output logic                               m_axis_tvalid,
    output logic                               m_axis_tlast,
    input  logic                               m_axis_tready,

    output logic [CNT_WIDTH-1:0]               pkt_cnt_0,
    output logic [CNT_WIDTH-1:0]               pkt_cnt_1,
    output logic [CNT_WIDTH-1:0]               pkt_cnt_2,
    output logic [CNT_WIDTH-1:0]               pkt_cnt_3
);

    logic [C_S_AXIS_DATA_WIDTH-1:0]   s_tdata [NUM_SLAVES];
    logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_tkeep [NUM_SLAVES];
    logic [C_S_AXIS_TUSER_WIDTH-1:0]  s_tuser [NUM_SLAVES];
    logic [NUM_SLAVES-1:0]            s_tvalid;
    logic [NUM_SLAVES-1:0]            s_tlast;
    logic [NUM_SLAVES-1:0]            s_tready;

    assign s_tdata[0] = s_axis_0_tdata;
    assign s_tdata[1] = s_axis_1_tdata;
    assign s_tdata[2] = s_axis_2_tdata;
    assign s_tdata[3] = s_axis_3_tdata;
    assign s_tkeep[0] = s_axis_0_tkeep;
    assign s_tkeep[1] = s_axis_1_tkeep;
    assign s_tkeep[2] = s_axis_2_tkeep;
    assign s_tkeep[3] = s_axis_3_tkeep;
    assign s_tuser[0] = s_axis_0_tuser;
    assign s_tuser[1] = s_axis_1_tuser;
    assign s_tuser[2] = s_axis_2_tuser;
    assign s_tuser[3] = s_axis_3_tuser;
    assign s_tvalid   = {s_axis_3_tvalid, s_axis_2_tvalid, s_axis_1_tvalid, s_axis_0_tvalid};
    assign s_tlast    = {s_axis_3_tlast,  s_axis_2_tlast,  s_axis_1_tlast,  s_axis_0_tlast};

    assign s_axis_0_tready = s_tready[0];
    assign s_axis_1_tready = s_tready[1];
    assign s_axis_2_tready = s_tready[2];
    assign s_axis_3_tready = s_tready[3];

    state_e state_q;
    grant_t grant_q;
    grant_t last_grant_q;
    grant_t winner;
    logic   any_valid;
    logic   fwd;
    logic   pkt_done;

    rr_priority_select u_rr_sel (
        .valid_i      (s_tvalid),
        .last_grant_i (last_grant_q),
        .winner_o     (winner),
        .any_valid_o  (any_valid)
    );

    assign fwd      = (state_q == ST_FORWARD);
    assign pkt_done = fwd && s_tvalid[grant_q] && m_axis_tready && s_tlast[grant_q];

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= grant_t'(NUM_SLAVES - 1);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_valid) begin
                        grant_q <= winner;
                        state_q <= ST_FORWARD;
                    end
                end
                ST_FORWARD: begin
                    if (pkt_done) begin
                        last_grant_q <= grant_q;
                        state_q      <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Pure mux of the granted slave; nothing is buffered, so idle drives zeros.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_tready      = '0;
        if (fwd) begin
            m_axis_tdata      = s_tdata[grant_q];
            m_axis_tkeep      = s_tkeep[grant_q];
            m_axis_tuser      = s_tuser[grant_q];
            m_axis_tvalid     = s_tvalid[grant_q];
            m_axis_tlast      = s_tlast[grant_q];
            s_tready[grant_q] = m_axis_tready;
        end
    end

    logic [CNT_WIDTH-1:0] cnt_w [NUM_SLAVES];

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_cnt
        logic [CNT_WIDTH-1:0] cnt_q;
        always_ff @(posedge axis_aclk or posedge axis_reset) begin
            if (axis_reset) begin
                cnt_q <= '0;
            end else if (pkt_done && (grant_q == grant_t'(g))) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
        assign cnt_w[g] = cnt_q;
    end

    assign pkt_cnt_0 = cnt_w[0];
    assign pkt_cnt_1 = cnt_w[1];
    assign pkt_cnt_2 = cnt_w[2];
    assign pkt_cnt_3 = cnt_w[3];

endmodule

// File: tb/tb_output_p4_arbiter.sv
// Scoreboard bench for output_p4_arbiter: directed packets per slave, a
// monitor pops expected beats in the hand-computed arbitration order.
module tb_output_p4_arbiter;

    localparam int DW = 256;
    localparam int KW = 32;
    localparam int UW = 128;
    localparam int CW = 32;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    beat_t sq[4][$];
    beat_t exp_q[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_tready = 1'b1;

    logic [DW-1:0] s_tdata [4];
    logic [KW-1:0] s_tkeep [4];
    logic [UW-1:0] s_tuser [4];
    logic [3:0]    s_tvalid;
    logic [3:0]    s_tlast;
    logic [3:0]    s_tready;

    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic [UW-1:0] m_tuser;
    logic          m_tvalid;
    logic          m_tlast;
    logic [CW-1:0] cnt [4];

    logic [CW-1:0] exp_cnt [4];
    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int beat_cyc[$];
    bit log_en = 1'b0;

    always #5 clk = ~clk;

    output_p4_arbiter #(
        .C_M_AXIS_DATA_WIDTH  (DW),
        .C_S_AXIS_DATA_WIDTH  (DW),
        .C_M_AXIS_TUSER_WIDTH (UW),
        .C_S_AXIS_TUSER_WIDTH (UW),
        .CNT_WIDTH            (CW)
    ) dut (
        .axis_aclk       (clk),
        .axis_reset      (rst),
        .s_axis_0_tdata  (s_tdata[0]), .s_axis_0_tkeep (s_tkeep[0]), .s_axis_0_tuser (s_tuser[0]),
        .s_axis_0_tvalid (s_tvalid[0]), .s_axis_0_tlast (s_tlast[0]), .s_axis_0_tready (s_tready[0]),
        .s_axis_1_tdata  (s_tdata[1]), .s_axis_1_tkeep (s_tkeep[1]), .s_axis_1_tuser (s_tuser[1]),
        .s_axis_1_tvalid (s_tvalid[1]), .s_axis_1_tlast (s_tlast[1]), .s_axis_1_tready (s_tready[1]),
        .s_axis_2_tdata  (s_tdata[2]), .s_axis_2_tkeep (s_tkeep[2]), .s_axis_2_tuser (s_tuser[2]),
        .s_axis_2_tvalid (s_tvalid[2]), .s_axis_2_tlast (s_tlast[2]), .s_axis_2_tready (s_tready[2]),
        .s_axis_3_tdata  (s_tdata[3]), .s_axis_3_tkeep (s_tkeep[3]), .s_axis_3_tuser (s_tuser[3]),
        .s_axis_3_tvalid (s_tvalid[3]), .s_axis_3_tlast (s_tlast[3]), .s_axis_3_tready (s_tready[3]),
        .m_axis_tdata    (m_tdata),
        .m_axis_tkeep    (m_tkeep),
        .m_axis_tuser    (m_tuser),
        .m_axis_tvalid   (m_tvalid),
        .m_axis_tlast    (m_tlast),
        .m_axis_tready   (m_tready),
        .pkt_cnt_0       (cnt[0]),
        .pkt_cnt_1       (cnt[1]),
        .pkt_cnt_2       (cnt[2]),
        .pkt_cnt_3       (cnt[3])
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    function automatic beat_t mk(input int src, input int pid, input int b, input bit last);
        beat_t t;
        t.data = {8{8'(src), 8'(pid), 8'(b), 8'hA5}};
        t.keep = last ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        t.user = {80'h0, 8'(src), 8'(pid), 8'(b), 8'h00, 16'hBEEF};
        t.last = last;
        return t;
    endfunction

    task automatic push_pkt(input int src, input int pid, input int n);
        for (int b = 0; b < n; b++) begin
            beat_t t = mk(src, pid, b, b == n - 1);
            sq[src].push_back(t);
            exp_q.push_back(t);
        end
        exp_cnt[src] = exp_cnt[src] + 1;
    endtask

    task automatic flush_all();
        exp_q.delete();
        for (int i = 0; i < 4; i++) sq[i].delete();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk); #4;
            n++;
        end
        chk({name, "_drained"}, DW'(exp_q.size() == 0), DW'(1));
        if (exp_q.size() != 0) flush_all();
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_cnts(input string tag);
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s_pkt_cnt_%0d", tag, k), DW'(cnt[k]), DW'(exp_cnt[k]));
    endtask

    task automatic zero_outputs(input string tag);
        chk({tag, "_m_tvalid"}, DW'(m_tvalid), '0);
        chk({tag, "_m_tdata"},  m_tdata, '0);
        chk({tag, "_m_tkeep"},  DW'(m_tkeep), '0);
        chk({tag, "_m_tuser"},  DW'(m_tuser), '0);
        chk({tag, "_m_tlast"},  DW'(m_tlast), '0);
        chk({tag, "_s_treadys"}, DW'(s_tready), '0);
    endtask

    // Slave drivers: sample handshake just before the edge, update payload just after.
    initial begin : drv
        logic [3:0] hs;
        s_tvalid = '0;
        s_tlast  = '0;
        for (int i = 0; i < 4; i++) begin
            s_tdata[i] = '0; s_tkeep[i] = '0; s_tuser[i] = '0;
        end
        forever begin
            @(negedge clk); #3;
            hs = s_tvalid & s_tready;
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                if (hs[i] && !rst && sq[i].size() > 0) void'(sq[i].pop_front());
                if (sq[i].size() > 0) begin
                    s_tvalid[i] = 1'b1;
                    s_tdata[i]  = sq[i][0].data;
                    s_tkeep[i]  = sq[i][0].keep;
                    s_tuser[i]  = sq[i][0].user;
                    s_tlast[i]  = sq[i][0].last;
                end else begin
                    s_tvalid[i] = 1'b0;
                    s_tlast[i]  = 1'b0;
                end
            end
        end
    end

    initial begin : mon
        beat_t e;
        forever begin
            @(negedge clk); #3;
            cyc++;
            if (!rst && m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_beat: got tdata %h, required no beat", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_tdata", m_tdata, e.data);
                    chk("beat_tkeep", DW'(m_tkeep), DW'(e.keep));
                    chk("beat_tuser", DW'(m_tuser), DW'(e.user));
                    chk("beat_tlast", DW'(m_tlast), DW'(e.last));
                    if (log_en) beat_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        int bad;
        logic pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) exp_cnt[k] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #3;
        zero_outputs("reset");
        chk_cnts("reset");
        @(negedge clk); rst = 1'b0;

        // Single 2-beat packet on slave 2, latency and ready isolation
        @(negedge clk); push_pkt(2, 1, 2);
        @(negedge clk); #3;
        chk("t1_idle_sample_tvalid", DW'(m_tvalid), DW'(0));
        @(negedge clk); #3;
        chk("t1_first_beat_tvalid", DW'(m_tvalid), DW'(1));
        chk("t1_readies_beat0", DW'(s_tready), DW'(4'b0100));
        @(negedge clk); #3;
        chk("t1_readies_beat1", DW'(s_tready), DW'(4'b0100));
        wait_drain("t1", 20);
        chk_cnts("t1");

        @(negedge clk); rst = 1'b1;
        for (int k = 0; k < 4; k++) exp_cnt[k] = '0;
        @(negedge clk); rst = 1'b0;

        // Fairness: all four busy, two 3-beat packets each -> 0,1,2,3,0,1,2,3
        @(negedge clk);
        beat_cyc.delete();
        log_en = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < 4; s++) push_pkt(s, 2 + r, 3);
        wait_drain("t2", 200);
        log_en = 1'b0;
        chk("t2_beat_count", DW'(beat_cyc.size()), DW'(24));
        bad = 0;
        for (int i = 0; i < beat_cyc.size(); i++)
            if (beat_cyc[i] - beat_cyc[0] != (i / 3) * 4 + (i % 3)) bad++;
        chk("t2_one_idle_between_pkts", DW'(bad), DW'(0));
        chk_cnts("t2");

        // Backpressure on slave 1 while slave 3 waits
        @(negedge clk); push_pkt(1, 4, 4); push_pkt(3, 5, 2);
        n = 0;
        do begin
            @(negedge clk); #3;
            n++;
        end while (!m_tvalid && n < 20);
        chk("t3_granted", DW'(m_tvalid), DW'(1));
        chk("t3_readies_at_grant", DW'(s_tready), DW'(4'b0010));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); m_tready = pat[i];
            #3;
            chk("t3_s1_tready_mirror", DW'(s_tready[1]), DW'(pat[i]));
            chk("t3_s3_waits", DW'(s_tready[3]), DW'(0));
            chk("t3_m_tvalid_held", DW'(m_tvalid), DW'(1));
        end
        @(negedge clk); m_tready = 1'b1;
        wait_drain("t3", 40);
        chk_cnts("t3");

        // Single-beat packets alternating 0,3,0,3
        @(negedge clk);
        push_pkt(0, 6, 1); push_pkt(3, 7, 1); push_pkt(0, 8, 1); push_pkt(3, 9, 1);
        wait_drain("t4", 40);
        chk_cnts("t4");

        // Reset mid-packet on slave 0
        @(negedge clk); push_pkt(0, 10, 4);
        n = 0;
        while (exp_q.size() > 2 && n < 30) begin
            @(negedge clk); #4;
            n++;
        end
        chk("t5_reached_mid_packet", DW'(exp_q.size() <= 2), DW'(1));
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        zero_outputs("t5_reset_mid");
        flush_all();
        for (int k = 0; k < 4; k++) exp_cnt[k] = '0;
        chk_cnts("t5_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #3;
        chk("t5_idle_after_release", DW'(m_tvalid), DW'(0));
        @(negedge clk); push_pkt(0, 11, 1); push_pkt(1, 12, 1);
        wait_drain("t5", 30);
        chk_cnts("t5");

        // Counter wrap on slave 0
        @(negedge clk);
        force dut.g_cnt[0].cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.g_cnt[0].cnt_q;
        exp_cnt[0] = 32'hFFFF_FFFF;
        #1;
        chk("t6_preload", DW'(cnt[0]), DW'(32'hFFFF_FFFF));
        @(negedge clk); push_pkt(0, 13, 2);
        wait_drain("t6", 30);
        chk("t6_cnt_wrap", DW'(cnt[0]), DW'(0));
        chk_cnts("t6");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
